// File: rtl/xor_acc_arbiter.sv
// xor_acc_arbiter: round-robin arbiter in front of a shared W-bit XOR accumulator.
// Each granted requester either XORs its operand into the accumulator or clears it.
// A three-state FSM (IDLE -> GRANT -> ACK) handles one operation per three cycles.
// Optional feature: define XOR_ACC_PARITY_EN to add the registered acc_par output.
module xor_acc_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ-1:0]   req_clr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      acc,
  output logic              busy,
  output logic [7:0]        op_cnt
`ifdef XOR_ACC_PARITY_EN
  ,
  output logic              acc_par
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StGrant, StAck} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win_q, win_d;
  logic            busy_q;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  int unsigned     cand;

  // Round-robin search starting just after the last completed winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = (32'(last_q) + off) % NREQ;
      if (!pick_found && req[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from these _d values.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    ack_d   = '0;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          win_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // A requester that dropped req before completion aborts without side effects.
        if (req[win_q]) begin
          acc_d   = req_clr[win_q] ? '0 : (acc_q ^ req_data[win_q*W +: W]);
          cnt_d   = cnt_q + 8'd1;
          last_d  = win_q;
          ack_d   = NREQ'(1) << win_q;
          state_d = StAck;
        end else begin
          state_d = StIdle;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 with first priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ack_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      win_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      busy_q  <= (state_d != StIdle);
    end
  end

`ifdef XOR_ACC_PARITY_EN
  logic par_q;

  // Parity tracks the accumulator value being registered this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^acc_d;
    end
  end

  assign acc_par = par_q;
`else
  // No parity output in this build.
`endif

  assign gnt    = gnt_q;
  assign ack    = ack_q;
  assign acc    = acc_q;
  assign busy   = busy_q;
  assign op_cnt = cnt_q;

endmodule

// File: tb/tb_xor_acc_arbiter.sv
// Scoreboard bench for xor_acc_arbiter: driver pushes expected ack/acc/op_cnt per operation,
// a negedge monitor pops and compares whenever the DUT pulses ack.
// Define XOR_ACC_PARITY_EN to also exercise acc_par.
module tb_xor_acc_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 6;

  typedef struct packed {
    logic [NREQ-1:0] ack;
    logic [W-1:0]    acc;
    logic [7:0]      cnt;
  } exp_t;

  localparam int          RR_GNT [5] = '{0, 1, 2, 3, 0};
  localparam logic [5:0]  RR_ACC [5] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h0E};

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_clr;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      acc;
  logic              busy;
  logic [7:0]        op_cnt;
`ifdef XOR_ACC_PARITY_EN
  logic              acc_par;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q [$];
  exp_t mon_e;

  xor_acc_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_clr  (req_clr),
    .gnt      (gnt),
    .ack      (ack),
    .acc      (acc),
    .busy     (busy),
    .op_cnt   (op_cnt)
`ifdef XOR_ACC_PARITY_EN
    ,
    .acc_par  (acc_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp_v);
    end
  endtask

  // Monitor: every ack pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && ack !== '0) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: got ack=%b acc=%h op_cnt=%0d required no ack",
                 ack, acc, op_cnt);
      end else begin
        mon_e = sb_q.pop_front();
        if (ack !== mon_e.ack || acc !== mon_e.acc || op_cnt !== mon_e.cnt) begin
          failures++;
          $display("FAIL ack_result: got ack=%b acc=%h op_cnt=%0d required ack=%b acc=%h op_cnt=%0d",
                   ack, acc, op_cnt, mon_e.ack, mon_e.acc, mon_e.cnt);
        end
      end
    end
  end

  // One operation by a single requester; starts and ends just after a posedge in IDLE.
  task automatic op(input int idx, input logic [W-1:0] d, input logic c,
                    input logic [W-1:0] e_acc, input logic [7:0] e_cnt);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    req_data[idx*W +: W] = d;
    req_clr[idx] = c;
    req[idx] = 1'b1;
    sb_q.push_back('{ack: oh, acc: e_acc, cnt: e_cnt});
    @(posedge clk); #1;
    chk("op_gnt", 32'(gnt), 32'(oh));
    @(posedge clk); #1;
    req[idx] = 1'b0;
    req_clr[idx] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    req_clr  = '0;
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_op_cnt", 32'(op_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single request with latency check.
    req_data[0 +: W] = 6'h2A;
    req[0] = 1'b1;
    sb_q.push_back('{ack: 4'b0001, acc: 6'h2A, cnt: 8'd1});
    chk("idle_gnt", 32'(gnt), 0);
    @(posedge clk); #1;
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_busy", 32'(busy), 1);
    chk("single_acc_pre", 32'(acc), 0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("ack_gnt_clear", 32'(gnt), 0);
    @(posedge clk); #1;
    chk("single_idle_busy", 32'(busy), 0);

    // Build 6'h15, then clear through requester 2.
    op(1, 6'h3F, 1'b0, 6'h15, 8'd2);
    chk("acc_before_clr", 32'(acc), 32'h15);
    op(2, 6'h3F, 1'b1, 6'h00, 8'd3);

    // Withdrawal: req held for one cycle only.
    req_data[1*W +: W] = 6'h0F;
    req[1] = 1'b1;
    @(posedge clk); #1;
    chk("wd_gnt", 32'(gnt), 32'h2);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("wd_gnt_clear", 32'(gnt), 0);
    chk("wd_busy", 32'(busy), 0);
    chk("wd_acc", 32'(acc), 0);
    chk("wd_op_cnt", 32'(op_cnt), 3);
    @(posedge clk); #1;
    chk("wd_no_ack", 32'(ack), 0);

    // Mid-operation reset.
    op(3, 6'h11, 1'b0, 6'h11, 8'd4);
    req_data[2*W +: W] = 6'h22;
    req[2] = 1'b1;
    @(posedge clk); #1;
    chk("mr_gnt", 32'(gnt), 32'h4);
    #2 reset = 1'b0;
    #1;
    chk("mr_acc", 32'(acc), 0);
    chk("mr_gnt_clear", 32'(gnt), 0);
    chk("mr_ack", 32'(ack), 0);
    chk("mr_op_cnt", 32'(op_cnt), 0);
    chk("mr_busy", 32'(busy), 0);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Round-robin with all requesters held.
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = W'(1 << i);
    for (int k = 0; k < 5; k++)
      sb_q.push_back('{ack: NREQ'(1) << RR_GNT[k], acc: RR_ACC[k], cnt: 8'(k + 1)});
    req = '1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("rr_gnt", 32'(gnt), 32'(1) << RR_GNT[k]);
      @(posedge clk);
      @(posedge clk); #1;
    end
    req = '0;

    // Run op_cnt through its wrap.
    for (int k = 0; k < 251; k++) op(0, 6'h00, 1'b0, 6'h0E, 8'(6 + k));
    chk("op_cnt_wrap", 32'(op_cnt), 0);

    // Parity values.
    op(1, 6'h09, 1'b0, 6'h07, 8'd1);
`ifdef XOR_ACC_PARITY_EN
    chk("acc_par_07", 32'(acc_par), 1);
`endif
    op(2, 6'h04, 1'b0, 6'h03, 8'd2);
`ifdef XOR_ACC_PARITY_EN
    chk("acc_par_03", 32'(acc_par), 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_acc_arbiter.md
XOR_ACC_ARBITER -- requirements
Module: xor_acc_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter W, default 6: accumulator and data width.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester operation request, level, held until ack.
REQ-006 req_data  input  NREQ*W  operand of requester i at bits [i*W +: W].
REQ-007 req_clr  input  NREQ  qualifies req: 1 = clear accumulator, 0 = XOR operand.
REQ-008 gnt  output  NREQ  one-hot grant; all zero when no grant is active.
REQ-009 ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 acc  output  W  registered accumulator value.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 op_cnt  output  8  count of completed operations, wraps 255 -> 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, GRANT, ACK; all outputs registered.
REQ-014 IDLE: if any req bit is set, the block SHALL select a winner round-robin, searching from (last+1) mod NREQ upward, register gnt one-hot, and go to GRANT.
REQ-015 IDLE with req all zero SHALL stay in IDLE with gnt = 0.
REQ-016 GRANT with req[winner] = 1: acc SHALL become 0 if req_clr[winner] = 1, else acc XOR req_data[winner], sampled in this cycle; op_cnt SHALL increment; last SHALL become winner; next state ACK.
REQ-017 GRANT with req[winner] = 0 (withdrawal) SHALL abort: acc, op_cnt, and last unchanged, no ack, gnt cleared, next state IDLE.
REQ-018 ACK: ack[winner] SHALL be 1 for exactly this cycle, gnt SHALL be cleared, next state IDLE.
REQ-019 Latency: req seen in cycle N -> gnt in N+1, acc updated visible N+2 with ack in N+2, next arbitration in N+3; peak throughput 1 op per 3 cycles.
REQ-020 Requests from other requesters during GRANT/ACK SHALL be ignored until IDLE.
REQ-021 A requester still asserting req in the cycle after its ack SHALL be treated as a new request.
REQ-022 Simultaneous requests SHALL be served strictly round-robin; no requester is starved for more than NREQ operations.
REQ-023 XOR arithmetic is exactly W bits; no carry, no saturation.

Reset
REQ-024 reset low SHALL immediately force: state IDLE, gnt 0, ack 0, acc 0, op_cnt 0, busy 0, last = NREQ-1 (so requester 0 has first priority).
REQ-025 Reset asserted mid-operation SHALL discard the operation with no ack; deassertion SHALL resume at IDLE on the next posedge.

Configuration
REQ-026 With macro XOR_ACC_PARITY_EN defined, output acc_par (1 bit) SHALL exist, registered, equal to the XOR-reduction of the next acc value, and 0 in reset.
REQ-027 Without XOR_ACC_PARITY_EN, port acc_par and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Single request: reset, req=0001, data0=6'h2A, clr=0 -> gnt=0001 at N+1, acc=6'h2A and ack=0001 at N+2, op_cnt=1.
REQ-029 Round-robin: req=1111 held and re-asserted after each ack, data_i = 6'h01<<i -> grant order 0,1,2,3,0; acc sequence 01,03,07,0F,0E.
REQ-030 Clear: acc=6'h15, req=0100 with clr[2]=1 -> acc=0 at ack, ack=0100.
REQ-031 Withdrawal: req=0010 for one cycle only -> gnt=0010 for one cycle, no ack, acc and op_cnt unchanged, back to IDLE.
REQ-032 Mid-op reset: reset low during GRANT -> acc=0, gnt=0, ack=0, op_cnt=0 immediately; after release req=0001 is granted first.
REQ-033 Wrap and parity: 256 completed ops -> op_cnt=0; with XOR_ACC_PARITY_EN, acc=6'h07 -> acc_par=1, acc=6'h03 -> acc_par=0.
